// File: rtl/keypad_pkg.sv
// Shared FSM states, scan-code field positions and idle column value for keypad_emulator.
// Bounce states exist only when KEYPAD_EMU_BOUNCE_EN is defined.
package keypad_pkg;
  localparam int SCAN_W  = 4;
  localparam int ROW_MSB = 3;
  localparam int ROW_LSB = 2;
  localparam int COL_MSB = 1;
  localparam int COL_LSB = 0;

  localparam logic [SCAN_W-1:0] COL_IDLE = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    GAP     = 3'd2
`ifdef KEYPAD_EMU_BOUNCE_EN
    ,
    BNC_IN  = 3'd3,
    BNC_OUT = 3'd4
`endif
  } kp_state_t;
endpackage

// File: rtl/keypad_bounce_gen.sv
// Contact bounce generator: BOUNCE_PULSES pairs of BOUNCE_CYCLES-long half-periods after start.
// polarity=0 begins closed (press bounce), polarity=1 begins open (release bounce).
module keypad_bounce_gen #(
  parameter int BOUNCE_CYCLES = 16,
  parameter int BOUNCE_PULSES = 3
) (
  input  logic CLK,
  input  logic RESET,
  input  logic start,
  input  logic polarity,
  output logic contact,
  output logic finished
);
  localparam int TW = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
  localparam int PW = (BOUNCE_PULSES > 0) ? $clog2(BOUNCE_PULSES + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(BOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(BOUNCE_PULSES - 1);

  logic          active;
  logic          half;
  logic          pol;
  logic [TW-1:0] timer;
  logic [PW-1:0] pulses;
  logic          half_end;

  assign half_end = (timer == T_LAST);
  assign finished = active && half_end && half && (pulses == P_LAST);
  assign contact  = active && (half == pol);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      active <= 1'b0;
      half   <= 1'b0;
      pol    <= 1'b0;
      timer  <= '0;
      pulses <= '0;
    end else if (start) begin
      active <= 1'b1;
      half   <= 1'b0;
      pol    <= polarity;
      timer  <= '0;
      pulses <= '0;
    end else if (active) begin
      if (half_end) begin
        timer <= '0;
        half  <= ~half;
        // A pulse completes at the end of its second half-period.
        if (half) begin
          pulses <= pulses + PW'(1);
          if (pulses == P_LAST) active <= 1'b0;
        end
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end
endmodule

// File: rtl/keypad_emulator.sv
// 4x4 keypad key-side emulator: pulls the latched key's COLUMN low while its ROW is driven low.
// Optional contact bounce around the hold phase is compiled in with KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator
  import keypad_pkg::*;
#(
`ifdef KEYPAD_EMU_BOUNCE_EN
  parameter int BOUNCE_CYCLES = 16,
  parameter int BOUNCE_PULSES = 3,
`endif
  parameter int RELEASE_GAP   = 32,
  parameter int HOLD_W        = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              KEY_REQ,
  input  logic [SCAN_W-1:0] KEY_CODE,
  input  logic [HOLD_W-1:0] HOLD_TIME,
  input  logic [3:0]        ROW,
  output logic [3:0]        COLUMN,
  output logic              BUSY,
  output logic              DONE
);
  localparam int GW = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(RELEASE_GAP - 1);

  kp_state_t         state;
  kp_state_t         nxt;
  logic [SCAN_W-1:0] code_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              done_q;
  logic              accept;
  logic              hold_last;
  logic              gap_last;
  logic              contact;

  assign accept    = (state == IDLE) && KEY_REQ;
  assign hold_last = (hold_cnt <= HOLD_W'(1));
  assign gap_last  = (gap_cnt == G_LAST);

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam bit BNC_ON = (BOUNCE_PULSES > 0);
  localparam kp_state_t PRESS_ST   = kp_state_t'(BNC_ON ? BNC_IN : HOLD);
  localparam kp_state_t RELEASE_ST = kp_state_t'(BNC_ON ? BNC_OUT : GAP);

  logic bnc_start;
  logic bnc_pol;
  logic bnc_contact;
  logic bnc_finished;

  // The generator is launched on the edge that enters each bounce phase.
  assign bnc_start = BNC_ON && (accept || ((state == HOLD) && hold_last));
  assign bnc_pol   = (state == HOLD);

  keypad_bounce_gen #(
    .BOUNCE_CYCLES(BOUNCE_CYCLES),
    .BOUNCE_PULSES(BOUNCE_PULSES)
  ) u_bounce (
    .CLK     (CLK),
    .RESET   (RESET),
    .start   (bnc_start),
    .polarity(bnc_pol),
    .contact (bnc_contact),
    .finished(bnc_finished)
  );
`else
  localparam kp_state_t PRESS_ST   = HOLD;
  localparam kp_state_t RELEASE_ST = GAP;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt     = state;
    contact = 1'b0;
    case (state)
      IDLE: if (KEY_REQ) nxt = PRESS_ST;
      HOLD: begin
        contact = 1'b1;
        if (hold_last) nxt = RELEASE_ST;
      end
      GAP:  if (gap_last) nxt = IDLE;
`ifdef KEYPAD_EMU_BOUNCE_EN
      BNC_IN: begin
        contact = bnc_contact;
        if (bnc_finished) nxt = HOLD;
      end
      BNC_OUT: begin
        contact = bnc_contact;
        if (bnc_finished) nxt = GAP;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      code_q   <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      done_q   <= 1'b0;
    end else begin
      // DONE lands in the first IDLE cycle so it never overlaps BUSY.
      done_q  <= (state == GAP) && gap_last;
      gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;
      if (accept) begin
        code_q   <= KEY_CODE;
        hold_cnt <= (HOLD_TIME == '0) ? HOLD_W'(1) : HOLD_TIME;
      end else if ((state == HOLD) && !hold_last) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end
    end
  end

  assign BUSY = (state != IDLE);
  assign DONE = done_q;

  always_comb begin
    COLUMN = COL_IDLE;
    if (contact && !ROW[code_q[ROW_MSB:ROW_LSB]]) COLUMN[code_q[COL_MSB:COL_LSB]] = 1'b0;
  end
endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: table of fixed presses, randomized presses against a cycle-count
// model, request-during-busy and mid-hold reset sequences.
module tb_keypad_emulator;
  localparam int HOLD_W = 16;
  localparam int RG     = 32;
  localparam int BC     = 16;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BP     = 3;
`else
  localparam int BP     = 0;
`endif
  localparam int BNC    = 2 * BC * BP;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              KEY_REQ = 1'b0;
  logic [3:0]        KEY_CODE = 4'h0;
  logic [HOLD_W-1:0] HOLD_TIME = '0;
  logic [3:0]        ROW = 4'h0;
  logic [3:0]        COLUMN;
  logic              BUSY;
  logic              DONE;

  int errors = 0;
  int checks = 0;

  keypad_emulator dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .KEY_REQ  (KEY_REQ),
    .KEY_CODE (KEY_CODE),
    .HOLD_TIME(HOLD_TIME),
    .ROW      (ROW),
    .COLUMN   (COLUMN),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Contact state k cycles after the accepting edge (k=1 is the first BUSY cycle).
  function automatic bit model_contact(input int k, input int h);
    int hh = (h == 0) ? 1 : h;
    int k2;
    int k3;
    if (k >= 1 && k <= BNC) return ((k - 1) / BC) % 2 == 0;
    k2 = k - BNC;
    if (k2 >= 1 && k2 <= hh) return 1'b1;
    k3 = k2 - hh;
    if (k3 >= 1 && k3 <= BNC) return ((k3 - 1) / BC) % 2 == 1;
    return 1'b0;
  endfunction

  function automatic int model_busy_len(input int h);
    return 2 * BNC + ((h == 0) ? 1 : h) + RG;
  endfunction

  function automatic logic [3:0] model_column(input bit c, input logic [3:0] code, input logic [3:0] row);
    logic [3:0] col = 4'hF;
    if (c && row[code[3:2]] == 1'b0) col[code[1:0]] = 1'b0;
    return col;
  endfunction

  // Requests a press in the current (idle) cycle and checks every cycle through DONE.
  task automatic press(input logic [3:0] code, input int hold, input logic [3:0] row,
                       input bit rand_row, input bit noise, input bit use_tab,
                       input logic [3:0] tab_col, input int tab_len);
    int total = model_busy_len(hold);
    int busy_cnt = 0;
    int done_cnt = 0;
    logic [3:0] exp_col;
    KEY_CODE  = code;
    HOLD_TIME = HOLD_W'(hold);
    ROW       = row;
    KEY_REQ   = 1'b1;
    #1;
    check("idle_busy", BUSY, 0);
    for (int k = 1; k <= total + 1; k++) begin
      @(posedge CLK);
      #1;
      if (noise && k <= total) begin
        KEY_REQ   = 1'($urandom_range(0, 1));
        KEY_CODE  = 4'($urandom);
        HOLD_TIME = HOLD_W'($urandom_range(0, 5));
      end else begin
        KEY_REQ = 1'b0;
      end
      if (rand_row) ROW = 4'($urandom);
      #1;
      if (use_tab) exp_col = model_contact(k, hold) ? tab_col : 4'hF;
      else         exp_col = model_column(model_contact(k, hold), code, ROW);
      check($sformatf("column k=%0d code=%0h", k, code), COLUMN, exp_col);
      check($sformatf("busy k=%0d", k), BUSY, k <= total);
      check($sformatf("done k=%0d", k), DONE, k == total + 1);
      busy_cnt += BUSY;
      done_cnt += DONE;
    end
    check("busy_len", busy_cnt, use_tab ? tab_len : total);
    check("done_count", done_cnt, 1);
  endtask

  typedef struct {
    logic [3:0] code;
    int         hold;
    logic [3:0] row;
    logic [3:0] col;
    int         len;
  } vec_t;

  vec_t tab[8];

  initial begin
    int done_seen;
    int busy_seen;

    tab[0] = '{4'hD, 100, 4'b0111, 4'b1101, 2 * BNC + 132};
    tab[1] = '{4'hD, 100, 4'b1110, 4'b1111, 2 * BNC + 132};
    tab[2] = '{4'h0,   5, 4'b1110, 4'b1110, 2 * BNC + 37};
    tab[3] = '{4'h0,   0, 4'b0000, 4'b1110, 2 * BNC + 33};
    tab[4] = '{4'hF,   3, 4'b0111, 4'b0111, 2 * BNC + 35};
    tab[5] = '{4'h6,   7, 4'b1101, 4'b1011, 2 * BNC + 39};
    tab[6] = '{4'h9,   1, 4'b1011, 4'b1101, 2 * BNC + 33};
    tab[7] = '{4'h6,   7, 4'b1011, 4'b1111, 2 * BNC + 39};

    RESET = 1'b0;
    ROW   = 4'h0;
    #12;
    check("reset_column", COLUMN, 4'hF);
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    // Back-to-back table presses also exercise the one-cycle idle dwell.
    for (int i = 0; i < 8; i++)
      press(tab[i].code, tab[i].hold, tab[i].row, 1'b0, 1'b0, 1'b1, tab[i].col, tab[i].len);

    // Requests and code changes while busy must not disturb the running press.
    press(4'h5, 10, 4'b1101, 1'b0, 1'b1, 1'b1, 4'b1101, 2 * BNC + 42);

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1;
      press(4'($urandom), $urandom_range(0, 40), 4'($urandom), 1'b1, 1'b1, 1'b0, 4'hF, 0);
    end

    // Reset in the middle of HOLD aborts immediately with no DONE afterwards.
    KEY_CODE  = 4'h0;
    HOLD_TIME = HOLD_W'(200);
    ROW       = 4'b1110;
    KEY_REQ   = 1'b1;
    @(posedge CLK);
    #1;
    KEY_REQ = 1'b0;
    repeat (BNC + 20) @(posedge CLK);
    #1;
    check("pre_reset_column", COLUMN, 4'b1110);
    #2;
    RESET = 1'b0;
    #1;
    check("midreset_column", COLUMN, 4'hF);
    check("midreset_busy", BUSY, 0);
    check("midreset_done", DONE, 0);
    #2;
    RESET = 1'b1;
    done_seen = 0;
    busy_seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge CLK);
      #1;
      done_seen += DONE;
      busy_seen += BUSY;
    end
    check("post_reset_done_count", done_seen, 0);
    check("post_reset_busy_count", busy_seen, 0);
    press(4'hA, 4, 4'b1011, 1'b0, 1'b0, 1'b1, 4'b1011, 2 * BNC + 36);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
